// File: rtl/divider_scheduler.sv
// Round-robin scheduler sharing one sequential divider among N requesters.
// Captures the granted operands, sequences start/busy, and returns quotients.
module divider_scheduler #(
  parameter int WIDTH   = 20,
  parameter int N       = 6,
  parameter int IDXW    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N-1:0]       req_sign,
  input  logic [N*WIDTH-1:0] req_dividend,
  input  logic [N*WIDTH-1:0] req_divisor,
  output logic [N-1:0]       done,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               err,
  output logic               div_start,
  output logic               div_sign,
  output logic [WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]   div_divisor,
  input  logic               div_ready,
  input  logic [WIDTH-1:0]   div_quotient
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDXW-1:0]  r_ptr;
  logic [IDXW-1:0]  r_grant;
  logic [IDXW-1:0]  w_g;
  logic [IDXW-1:0]  w_lo;
  logic [IDXW-1:0]  w_hi;
  logic             w_hit;
  logic             w_any;
  logic             w_zero;
  logic             w_tout;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_dvd;
  logic [WIDTH-1:0] w_dvs;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_sign;
  logic             r_err;

  // Prefer the lowest set bit at or above ptr; otherwise wrap to the lowest.
  always_comb begin
    w_lo  = '0;
    w_hi  = '0;
    w_hit = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        w_lo = IDXW'(k);
        if (IDXW'(k) >= r_ptr) begin
          w_hi  = IDXW'(k);
          w_hit = 1'b1;
        end
      end
    end
    w_g = w_hit ? w_hi : w_lo;
  end

  assign w_any  = |req;
  assign w_dvd  = req_dividend[w_g*WIDTH +: WIDTH];
  assign w_dvs  = req_divisor[w_g*WIDTH +: WIDTH];
  assign w_zero = (w_dvs == '0);
  assign w_tout = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) w_next = w_zero ? S_DONE : S_START;
      end
      S_START: w_next = S_BUSY;
      S_BUSY: begin
        if (div_ready || w_tout) w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_grant  <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_sign   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_g;
            r_dvd   <= w_dvd;
            r_dvs   <= w_dvs;
            r_sign  <= req_sign[w_g];
            if (w_zero) r_result <= '1;
          end
        end
        S_START: r_cnt <= '0;
        S_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (div_ready) begin
            r_result <= div_quotient;
          end else if (w_tout) begin
            r_result <= '1;
            r_err    <= 1'b1;
          end
        end
        S_DONE: begin
          r_ptr <= (r_grant == IDXW'(N - 1)) ? '0 : r_grant + 1'b1;
        end
      endcase
    end
  end

  assign done         = (r_state == S_DONE) ? (N'(1) << r_grant) : '0;
  assign busy         = (r_state != S_IDLE);
  assign div_start    = (r_state == S_START);
  assign result       = r_result;
  assign err          = r_err;
  assign div_sign     = r_sign;
  assign div_dividend = r_dvd;
  assign div_divisor  = r_dvs;

endmodule

// File: tb/tb_divider_scheduler.sv
// Directed bench for divider_scheduler with a behavioural divider model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_divider_scheduler;

  localparam int W  = 20;
  localparam int N  = 6;
  localparam int IW = 3;
  localparam int TO = 64;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   req_sign;
  logic [N*W-1:0] req_dividend;
  logic [N*W-1:0] req_divisor;
  logic [N-1:0]   done;
  logic [W-1:0]   result;
  logic           busy;
  logic           err;
  logic           div_start;
  logic           div_sign;
  logic [W-1:0]   div_dividend;
  logic [W-1:0]   div_divisor;
  logic           div_ready;
  logic [W-1:0]   div_quotient;

  int tests = 0;
  int fails = 0;
  int starts = 0;
  int lat = 4;
  bit withhold = 0;

  logic signed [W-1:0] sa;
  logic signed [W-1:0] sb;
  logic signed [W-1:0] sq;
  logic [W-1:0]        uq;

  divider_scheduler #(
    .WIDTH(W), .N(N), .IDXW(IW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_sign(req_sign),
    .req_dividend(req_dividend),
    .req_divisor(req_divisor),
    .done(done),
    .result(result),
    .busy(busy),
    .err(err),
    .div_start(div_start),
    .div_sign(div_sign),
    .div_dividend(div_dividend),
    .div_divisor(div_divisor),
    .div_ready(div_ready),
    .div_quotient(div_quotient)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: answers lat cycles after the start pulse unless withheld.
  initial begin
    div_ready    = 1'b0;
    div_quotient = '0;
    forever begin
      @(negedge clk);
      if (div_start) begin
        starts++;
        if (!withhold) begin
          if (div_sign) begin
            sa = div_dividend;
            sb = div_divisor;
            sq = sa / sb;
            uq = sq;
          end else begin
            uq = div_dividend / div_divisor;
          end
          repeat (lat - 1) @(negedge clk);
          div_quotient = uq;
          div_ready    = 1'b1;
          @(negedge clk);
          div_ready    = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < 300);
    tests++;
    assert (done != '0) else begin
      fails++;
      $error("FAIL wait_done: got no done after %0d cycles expected a pulse", n);
    end
  endtask

  task automatic set_op(input int k, input bit s, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    req_dividend[k*W +: W] = a;
    req_divisor[k*W +: W]  = b;
    req_sign[k]            = s;
    req[k]                 = 1'b1;
  endtask

  int n;
  int s0;
  bit seen_ready;
  bit bad;

  initial begin
    reset        = 1'b1;
    req          = '0;
    req_sign     = '0;
    req_dividend = '0;
    req_divisor  = '0;

    @(negedge clk);
    chk("rst done", 32'(done), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst err", 32'(err), 0);
    chk("rst start", 32'(div_start), 0);
    chk("rst result", 32'(result), 0);
    chk("rst dividend", 32'(div_dividend), 0);
    reset = 1'b0;

    // Single unsigned request on index 2
    set_op(2, 0, 20'd1000, 20'd10);
    @(negedge clk);
    chk("single start", 32'(div_start), 1);
    chk("single dvd", 32'(div_dividend), 1000);
    chk("single dvs", 32'(div_divisor), 10);
    chk("single sign", 32'(div_sign), 0);
    wait_done(n);
    chk("single lat", 32'(n), 4);
    chk("single done", 32'(done), 32'h04);
    chk("single result", 32'(result), 100);
    chk("single starts", 32'(starts), 1);
    req[2] = 1'b0;

    // All six requesters with ptr back at 0
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < N; k++) set_op(k, 0, 20'(70 * (k + 1)), 20'd7);
    for (int k = 0; k < N; k++) begin
      wait_done(n);
      chk("rr done", 32'(done), 32'(1 << k));
      chk("rr result", 32'(result), 32'(10 * (k + 1)));
      req[k] = 1'b0;
    end
    set_op(5, 0, 20'd500, 20'd5);
    set_op(0, 0, 20'd90, 20'd3);
    wait_done(n);
    chk("wrap first", 32'(done), 32'h01);
    chk("wrap first res", 32'(result), 30);
    req[0] = 1'b0;
    wait_done(n);
    chk("wrap second", 32'(done), 32'h20);
    chk("wrap second res", 32'(result), 100);
    req[5] = 1'b0;

    // Signed divide
    @(negedge clk);
    set_op(1, 1, 20'hFF800, 20'd640);
    wait_done(n);
    chk("signed done", 32'(done), 32'h02);
    chk("signed result", 32'(result), 32'hFFFFD);
    chk("signed mode", 32'(div_sign), 1);
    req[1] = 1'b0;

    // Divide by zero
    @(negedge clk);
    s0 = starts;
    set_op(3, 0, 20'd1234, 20'd0);
    wait_done(n);
    chk("div0 lat", 32'(n), 1);
    chk("div0 done", 32'(done), 32'h08);
    chk("div0 result", 32'(result), 32'hFFFFF);
    chk("div0 err", 32'(err), 0);
    chk("div0 nostart", 32'(starts), 32'(s0));
    req[3] = 1'b0;

    // Timeout, then a good operation keeps err set
    @(negedge clk);
    withhold = 1'b1;
    set_op(4, 0, 20'd50, 20'd5);
    wait_done(n);
    chk("tout lat", 32'(n), TO + 2);
    chk("tout done", 32'(done), 32'h10);
    chk("tout result", 32'(result), 32'hFFFFF);
    chk("tout err", 32'(err), 1);
    req[4]   = 1'b0;
    withhold = 1'b0;
    @(negedge clk);
    set_op(0, 0, 20'd100, 20'd4);
    wait_done(n);
    chk("post done", 32'(done), 32'h01);
    chk("post result", 32'(result), 25);
    chk("post err", 32'(err), 1);
    req[0] = 1'b0;

    // Reset while BUSY; the late div_ready must be ignored
    @(negedge clk);
    lat = 10;
    set_op(2, 0, 20'd1000, 20'd10);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!div_start && n < 10);
    chk("mid start", 32'(div_start), 1);
    repeat (2) @(negedge clk);
    chk("mid busy pre", 32'(busy), 1);
    reset = 1'b1;
    req   = '0;
    #1;
    chk("mid busy", 32'(busy), 0);
    chk("mid done", 32'(done), 0);
    chk("mid err", 32'(err), 0);
    chk("mid result", 32'(result), 0);
    chk("mid start0", 32'(div_start), 0);
    chk("mid dvd", 32'(div_dividend), 0);
    chk("mid dvs", 32'(div_divisor), 0);
    chk("mid sign", 32'(div_sign), 0);
    @(negedge clk);
    reset = 1'b0;
    seen_ready = 1'b0;
    bad = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (div_ready) seen_ready = 1'b1;
      if (done != '0 || busy) bad = 1'b1;
    end
    chk("stale ready seen", 32'(seen_ready), 1);
    chk("stale no done", 32'(bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
